uart_rx: RTL and testbench

- Serial UART receiver; the receive-side counterpart to the core's UART transmitter.
- Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) from an asynchronous line.
- Holds each received byte in a one-deep register for the load/store unit to read over a ready/ack handshake.
- Reports framing and overrun errors.
- Runs on the same divided core clock as the rest of the pipeline.

---
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-deep holding register, a ready/ack read handshake,
// and sticky framing and overrun flags.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    input  logic       rd_en_i,
    output logic [7:0] data_o,
    output logic       byte_ready_o,
    output logic       rx_done_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e          state, state_next;
    logic            rx_meta, rx_s;
    logic [CntW-1:0] cnt, cnt_next;
    logic [2:0]      bit_idx, bit_idx_next;
    logic [7:0]      shift, shift_next;
    logic [7:0]      data, data_next;
    logic            ready, ready_next;
    logic            done, done_next;
    logic            ferr, ferr_next;
    logic            ovr, ovr_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Synchronizer resets to the idle line level so reset never looks like a start bit.
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= StIdle;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data    <= '0;
            ready   <= 1'b0;
            done    <= 1'b0;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            data    <= data_next;
            ready   <= ready_next;
            done    <= done_next;
            ferr    <= ferr_next;
            ovr     <= ovr_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        data_next    = data;
        ready_next   = ready;
        done_next    = 1'b0;
        ferr_next    = ferr;
        ovr_next     = ovr;

        if (rd_en_i) begin
            ready_next = 1'b0;
            ferr_next  = 1'b0;
            ovr_next   = 1'b0;
        end

        unique case (state)
            StIdle: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = StStart;
                end
            end
            StStart: begin
                if (cnt == HalfLast) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt == BitLast) begin
                    cnt_next            = '0;
                    shift_next[bit_idx] = rx_s;
                    bit_idx_next        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt == BitLast) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        state_next = StIdle;
                        done_next  = 1'b1;
                        // A read on the completion edge frees the holding register in time.
                        if (!ready || rd_en_i) begin
                            data_next  = shift;
                            ready_next = 1'b1;
                        end else begin
                            ovr_next = 1'b1;
                        end
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = StIdle;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = StIdle;
            end
        endcase
    end

    assign data_o       = data;
    assign byte_ready_o = ready;
    assign rx_done_o    = done;
    assign frame_err_o  = ferr;
    assign overrun_o    = ovr;
    assign busy_o       = (state != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level event model compared every cycle, plus directed literal checks.
module tb_uart_rx;

    localparam int N   = 16;
    localparam int H   = N / 2;
    localparam int LAT = 2 + H + 9 * N;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       rx_i    = 1'b1;
    logic       rd_en_i = 1'b0;
    logic [7:0] data_o;
    logic       byte_ready_o, rx_done_o, frame_err_o, overrun_o, busy_o;

    int cyc       = 0;
    int errors    = 0;
    int checks    = 0;
    int last_e0   = 0;
    int frame_seq = 0;

    // Expected frame completions: edge index, byte, stop-bit level.
    int         ev_cyc[$];
    logic [7:0] ev_byte[$];
    logic       ev_good[$];

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_i        (rx_i),
        .rd_en_i     (rd_en_i),
        .data_o      (data_o),
        .byte_ready_o(byte_ready_o),
        .rx_done_o   (rx_done_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            rx_i = bits[i];
            if (i == 0) begin
                last_e0 = cyc + 1;
                ev_cyc.push_back(cyc + 1 + LAT);
                ev_byte.push_back(b);
                ev_good.push_back(stop);
                frame_seq++;
            end
            repeat (N - 1) @(posedge clk);
        end
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [8:0] bits;
        bits = {b, 1'b0};
        for (int i = 0; i <= nbits; i++) begin
            @(posedge clk);
            #1;
            rx_i = bits[i];
            repeat (N - 1) @(posedge clk);
        end
    endtask

    task automatic pulse_rd();
        @(posedge clk);
        #1;
        rd_en_i = 1'b1;
        @(posedge clk);
        #1;
        rd_en_i = 1'b0;
    endtask

    // Drive rd_en_i so that edge index e samples it.
    task automatic pulse_rd_at(input int e);
        while (cyc < e - 1) begin
            @(posedge clk);
            #1;
        end
        rd_en_i = 1'b1;
        @(posedge clk);
        #1;
        rd_en_i = 1'b0;
    endtask

    task automatic wait_done(input string name, output int t);
        int n;
        t = -1;
        n = 0;
        while (t < 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (rx_done_o === 1'b1) t = cyc;
        end
        check({name, " done seen"}, 32'(t >= 0), 32'd1);
    endtask

    task automatic wait_cyc(input int k);
        while (cyc != k) @(negedge clk);
    endtask

    // Model: apply the read/complete rules per edge, then compare all handshake outputs.
    initial begin : model
        logic [7:0] m_data, comp_byte;
        logic m_ready, m_done, m_ferr, m_ovr, rd_prev, rd_now, ready_before, comp, comp_good;
        m_data = '0; m_ready = 0; m_done = 0; m_ferr = 0; m_ovr = 0; rd_prev = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_data = '0; m_ready = 0; m_done = 0; m_ferr = 0; m_ovr = 0;
            end else begin
                rd_now    = rd_prev;
                comp      = 1'b0;
                comp_good = 1'b0;
                comp_byte = '0;
                if (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
                    comp      = 1'b1;
                    comp_good = ev_good.pop_front();
                    comp_byte = ev_byte.pop_front();
                    void'(ev_cyc.pop_front());
                end
                ready_before = m_ready;
                m_done       = comp && comp_good;
                if (rd_now) begin
                    m_ready = 0; m_ferr = 0; m_ovr = 0;
                end
                if (comp && comp_good) begin
                    if (!ready_before || rd_now) begin
                        m_data  = comp_byte;
                        m_ready = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (comp) begin
                    m_ferr = 1'b1;
                end
            end
            rd_prev = rd_en_i;
            check("model data_o", 32'(data_o), 32'(m_data));
            check("model byte_ready_o", 32'(byte_ready_o), 32'(m_ready));
            check("model rx_done_o", 32'(rx_done_o), 32'(m_done));
            check("model frame_err_o", 32'(frame_err_o), 32'(m_ferr));
            check("model overrun_o", 32'(overrun_o), 32'(m_ovr));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t, t1, t2, c, s;
        logic [7:0] d1, d2;

        @(posedge clk);
        #1;
        check("reset busy_o", 32'(busy_o), 0);
        check("reset byte_ready_o", 32'(byte_ready_o), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (N) @(posedge clk);

        // Single frame 0xA5
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_done("a5", t);
                check("a5 latency", 32'(t - last_e0), 32'd154);
                check("a5 data_o", 32'(data_o), 32'hA5);
                check("a5 frame_err_o", 32'(frame_err_o), 0);
                @(negedge clk);
                check("a5 done width", 32'(rx_done_o), 0);
            end
        join
        pulse_rd();
        check("a5 ack ready", 32'(byte_ready_o), 0);
        check("a5 ack data", 32'(data_o), 32'hA5);

        // Back-to-back 0x00 then 0xFF, acked
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                wait_done("b2b first", t1);
                d1 = data_o;
                pulse_rd();
                wait_done("b2b second", t2);
                d2 = data_o;
                pulse_rd();
            end
        join
        check("b2b spacing", 32'(t2 - t1), 32'd160);
        check("b2b data0", 32'(d1), 32'h00);
        check("b2b data1", 32'(d2), 32'hFF);

        // Glitch: 4-cycle low pulse
        repeat (N) @(posedge clk);
        #1;
        rx_i = 1'b0;
        c    = cyc;
        repeat (4) @(posedge clk);
        #1;
        rx_i = 1'b1;
        wait_cyc(c + 6);
        check("glitch busy high", 32'(busy_o), 1);
        wait_cyc(c + 12);
        check("glitch busy dropped", 32'(busy_o), 0);

        // Framing error on 0x3C, line held low
        send_frame(8'h3C, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        check("ferr flag", 32'(frame_err_o), 1);
        check("ferr wait_idle busy", 32'(busy_o), 1);
        rx_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("ferr idle after line high", 32'(busy_o), 0);
        repeat (N) @(posedge clk);
        send_frame(8'h11, 1'b1);
        check("ferr next data", 32'(data_o), 32'h11);
        check("ferr sticky", 32'(frame_err_o), 1);
        pulse_rd();
        check("ferr cleared", 32'(frame_err_o), 0);

        // Overrun: 0x55 unread, then 0x66
        send_frame(8'h55, 1'b1);
        send_frame(8'h66, 1'b1);
        check("ovr flag", 32'(overrun_o), 1);
        check("ovr data kept", 32'(data_o), 32'h55);
        check("ovr ready", 32'(byte_ready_o), 1);
        pulse_rd();
        check("ovr cleared", 32'(overrun_o), 0);
        send_frame(8'h55, 1'b1);
        s = frame_seq;
        fork
            send_frame(8'h66, 1'b1);
            begin
                wait (frame_seq != s);
                pulse_rd_at(last_e0 + 154);
            end
        join
        check("ack-on-complete data", 32'(data_o), 32'h66);
        check("ack-on-complete overrun", 32'(overrun_o), 0);
        check("ack-on-complete ready", 32'(byte_ready_o), 1);

        // Reset during data bit 4 of 0x81
        repeat (N) @(posedge clk);
        send_partial(8'h81, 4);
        @(posedge clk);
        #1;
        rx_i = 1'b0;
        repeat (N / 2) @(posedge clk);
        #2;
        check("midframe busy", 32'(busy_o), 1);
        reset = 1'b1;
        #1;
        check("midframe reset data", 32'(data_o), 0);
        check("midframe reset ready", 32'(byte_ready_o), 0);
        check("midframe reset overrun", 32'(overrun_o), 0);
        check("midframe reset busy", 32'(busy_o), 0);
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (N) @(posedge clk);
        send_frame(8'h81, 1'b1);
        check("after reset data", 32'(data_o), 32'h81);
        check("after reset ready", 32'(byte_ready_o), 1);
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
